// File: rtl/ser_tx_arbiter.sv
// Two-requester round-robin arbiter feeding an MSB-first serializer (IDLE -> SHIFT -> DONE).
// Define SER_TX_PARITY_EN to append an even-parity bit after the data bits.
module ser_tx_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_a,
    input  logic [WIDTH-1:0] data_a,
    output logic             ready_a,
    input  logic             valid_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             ready_b,
    output logic             ser_o,
    output logic             ser_en_o,
    output logic             grant_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int CW = $clog2(WIDTH + 2);
`ifdef SER_TX_PARITY_EN
    localparam logic [CW-1:0] LAST = CW'(WIDTH + 1);
`else
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             prio_b;   // 1: B wins the next tie
    logic             idle;
    logic             pick_b;
    logic [WIDTH-1:0] word;
`ifdef SER_TX_PARITY_EN
    logic             par;
`endif

    always_comb begin
        idle    = (state == IDLE);
        pick_b  = valid_b & (~valid_a | prio_b);
        ready_a = idle & valid_a & ~pick_b;
        ready_b = idle & pick_b;
        word    = pick_b ? data_b : data_a;
    end

    // ser_o is registered one bit ahead: the MSB is loaded on acceptance,
    // then each SHIFT edge presents the next bit of the held word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            prio_b   <= 1'b0;
            ser_o    <= 1'b0;
            ser_en_o <= 1'b0;
            grant_o  <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
`ifdef SER_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (valid_a | valid_b) begin
                        state    <= SHIFT;
                        shreg    <= word;
                        cnt      <= CW'(1);
                        grant_o  <= pick_b;
                        prio_b   <= ~pick_b;
                        ser_o    <= word[WIDTH-1];
                        ser_en_o <= 1'b1;
                        busy_o   <= 1'b1;
`ifdef SER_TX_PARITY_EN
                        par      <= ^word;
`endif
                    end
                end
                SHIFT: begin
                    if (cnt == LAST) begin
                        state    <= DONE;
                        cnt      <= '0;
                        ser_o    <= 1'b0;
                        ser_en_o <= 1'b0;
                        done_o   <= 1'b1;
                    end else begin
                        cnt   <= cnt + CW'(1);
                        shreg <= {shreg[WIDTH-2:0], 1'b0};
`ifdef SER_TX_PARITY_EN
                        ser_o <= (cnt == CW'(WIDTH)) ? par : shreg[WIDTH-2];
`else
                        ser_o <= shreg[WIDTH-2];
`endif
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ser_tx_arbiter.sv
// Self-checking bench for ser_tx_arbiter: a transfer-phase model checked every cycle
// plus directed scenarios with literal expectations.
module tb_ser_tx_arbiter;
    localparam int W = 4;
`ifdef SER_TX_PARITY_EN
    localparam int L = W + 1;
`else
    localparam int L = W;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         valid_a = 1'b0, valid_b = 1'b0;
    logic [W-1:0] data_a = '0, data_b = '0;
    logic         ready_a, ready_b, ser_o, ser_en_o, grant_o, busy_o, done_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    ser_tx_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .valid_a(valid_a), .data_a(data_a), .ready_a(ready_a),
        .valid_b(valid_b), .data_b(data_b), .ready_b(ready_b),
        .ser_o(ser_o), .ser_en_o(ser_en_o), .grant_o(grant_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: phase 0 = idle, 1..L = bit phases, L+1 = done cycle.
    int           m_p = 0;
    logic [W-1:0] m_word = '0;
    logic         m_grant = 1'b0;
    logic         m_prio_b = 1'b0;

    function automatic logic m_bit(input int p, input logic [W-1:0] w);
        if (p <= W) return w[W-p];
        return ^w;
    endfunction

    always @(negedge clk) begin : model
        logic pb;
        logic en;
        if (!reset_n) begin
            m_p = 0; m_grant = 1'b0; m_prio_b = 1'b0;
            check("rst_ser_en", ser_en_o, 1'b0);
            check("rst_busy", busy_o, 1'b0);
            check("rst_done", done_o, 1'b0);
        end else begin
            pb = valid_b & (~valid_a | m_prio_b);
            en = (m_p >= 1) && (m_p <= L);
            check("m_ready_a", ready_a, (m_p == 0) && valid_a && !pb);
            check("m_ready_b", ready_b, (m_p == 0) && pb);
            check("m_ser_en", ser_en_o, en);
            check("m_ser", ser_o, en ? m_bit(m_p, m_word) : 1'b0);
            check("m_busy", busy_o, m_p != 0);
            check("m_done", done_o, m_p == L + 1);
            check("m_grant", grant_o, m_grant);
            if (m_p == 0) begin
                if (valid_a | valid_b) begin
                    m_p = 1; m_grant = pb; m_prio_b = !pb;
                    m_word = pb ? data_b : data_a;
                end
            end else if (m_p == L + 1) m_p = 0;
            else m_p++;
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic do_reset;
        tick;
        reset_n = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        tick;
        reset_n = 1'b1;
    endtask

    // Caller has just released reset or is in an idle cycle 0.
    task automatic send_a(input logic [W-1:0] w);
        valid_a = 1'b1; data_a = w;
        #1 check("lit_ready_a", ready_a, 1'b1);
        for (int k = 1; k <= L; k++) begin
            tick;
            if (k == 1) valid_a = 1'b0;
            #1;
            check("lit_ser", ser_o, m_bit(k, w));
            check("lit_ser_en", ser_en_o, 1'b1);
        end
        tick; #1 check("lit_done", done_o, 1'b1);
        tick; #1 check("lit_busy_low", busy_o, 1'b0);
        check("lit_done_low", done_o, 1'b0);
    endtask

    initial begin
        int t;
        int last_acc;
        #1;
        check("por_busy", busy_o, 1'b0);
        check("por_grant", grant_o, 1'b0);

        // Single A word, accepted on the first edge after reset release
        do_reset;
        send_a(4'b1011);
        send_a(4'b0111);
        send_a(4'b0110);

        // Tie fairness: both held high
        do_reset;
        valid_a = 1'b1; valid_b = 1'b1; data_a = 4'hA; data_b = 4'h5;
        last_acc = 0;
        #1;
        for (int i = 0; i < 4; i++) begin
            t = 0;
            while (!(ready_a | ready_b) && t < 20) begin tick; #1; t++; end
            check("tie_timeout", t < 20, 1'b1);
            check("tie_side_b", ready_b, i % 2);
            if (i > 0) check("tie_gap", cyc - last_acc, L + 2);
            last_acc = cyc;
            tick; #1;
        end
        valid_a = 1'b0; valid_b = 1'b0;
        repeat (L + 2) tick;

        // Busy backpressure: B raised in cycle 2 of an A transfer
        do_reset;
        valid_a = 1'b1; data_a = 4'hC;
        #1 check("bp_ready_a", ready_a, 1'b1);
        tick; valid_a = 1'b0;
        tick; valid_b = 1'b1; data_b = 4'h9;
        #1 check("bp_ready_b_c2", ready_b, 1'b0);
        for (int c = 3; c <= L + 1; c++) begin
            tick; #1 check("bp_ready_b_hold", ready_b, 1'b0);
        end
        tick; #1 check("bp_ready_b_acc", ready_b, 1'b1);
        tick; valid_b = 1'b0; data_b = 4'h0;
        #1 check("bp_b_msb", ser_o, 1'b1);
        tick; data_b = 4'h6;
        #1 check("bp_b_bit2", ser_o, 1'b0);
        repeat (L + 1) tick;

        // Reset in cycle 3 of a transfer
        do_reset;
        valid_a = 1'b1; data_a = 4'hF;
        tick; valid_a = 1'b0;
        tick;
        tick; reset_n = 1'b0;
        #1;
        check("rm_ser_en", ser_en_o, 1'b0);
        check("rm_busy", busy_o, 1'b0);
        check("rm_done", done_o, 1'b0);
        check("rm_grant", grant_o, 1'b0);
        tick; reset_n = 1'b1; valid_a = 1'b1; valid_b = 1'b1; data_b = 4'h3;
        #1;
        check("rm_tie_a", ready_a, 1'b1);
        check("rm_tie_b", ready_b, 1'b0);
        tick; valid_a = 1'b0; valid_b = 1'b0;
        repeat (L + 3) tick;

        // Idle hold for 20 cycles
        do_reset;
        repeat (20) begin
            tick; #1;
            check("idle_ready", {ready_a, ready_b}, 2'b00);
            check("idle_outs", {ser_o, ser_en_o, grant_o, busy_o, done_o}, 5'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ser_tx_arbiter.md
SER_TX_ARBITER -- requirements
Module: ser_tx_arbiter

Interface
REQ-001 SHALL provide parameter: WIDTH, 4, word width in bits; legal values 2..16.
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL provide port: reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL provide port: valid_a  input  1  requester A has a word.
REQ-005 SHALL provide port: data_a  input  WIDTH  requester A word.
REQ-006 SHALL provide port: ready_a  output  1  requester A word accepted this cycle.
REQ-007 SHALL provide ports valid_b, data_b and ready_b, identical to the A ports, for requester B.
REQ-008 SHALL provide port: ser_o  output  1  serial data bit, MSB first.
REQ-009 SHALL provide port: ser_en_o  output  1  ser_o holds a valid bit this cycle.
REQ-010 SHALL provide port: grant_o  output  1  owner of current/last transfer (0=A, 1=B).
REQ-011 SHALL provide port: busy_o  output  1  state is not IDLE.
REQ-012 SHALL provide port: done_o  output  1  one-cycle pulse at transfer end.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-014 SHALL, in IDLE with any valid high, accept one word:
- raise the granted requester's ready (combinational from valid, IDLE only).
- capture its data into a WIDTH-bit shift register.
- update grant_o.
- enter SHIFT on the same edge.
REQ-015 SHALL arbitrate round-robin:
- one valid: grant that requester.
- both valid: grant the requester not granted last.
- after reset, A wins the first tie.
REQ-016 SHALL never assert ready_a and ready_b in the same cycle; SHALL keep both ready low outside IDLE.
REQ-017 SHALL, in SHIFT, drive ser_o from the register MSB with ser_en_o=1 and shift left, zero-filled, each cycle for exactly WIDTH cycles.
REQ-018 SHALL give this latency: acceptance in cycle N -> data bits in cycles N+1..N+WIDTH -> done_o in N+WIDTH+1 (DONE state) -> IDLE in N+WIDTH+2.
REQ-019 SHALL track SHIFT length with a bit counter of ceil(log2(WIDTH+2)) bits that wraps to 0 on SHIFT exit.
REQ-020 SHALL drive ser_o=0 and ser_en_o=0 in IDLE and DONE.
REQ-021 SHALL not accept a new word in DONE; requesters SHALL hold valid until they see ready.
REQ-022 SHALL ignore changes to valid and data during SHIFT and DONE.
REQ-023 SHALL ignore a valid that drops before acceptance, with no side effect.

Reset
REQ-024 SHALL, while reset_n=0, immediately force:
- state IDLE, shift register 0, counter 0.
- ser_o=0, ser_en_o=0, busy_o=0, done_o=0, grant_o=0.
- round-robin pointer set so that A has priority.
REQ-025 SHALL abort any in-progress transfer on reset with no done_o pulse; the word is lost.
REQ-026 SHALL accept a word in the first rising edge after reset_n deasserts if valid is high.

Configuration
REQ-027 SHALL, when macro SER_TX_PARITY_EN is defined, make SHIFT last WIDTH+1 cycles:
- the extra final bit is even parity (XOR of the captured word) on ser_o with ser_en_o=1.
- done_o moves to N+WIDTH+2.
REQ-028 SHALL, without SER_TX_PARITY_EN, contain no parity logic and follow REQ-018 exactly.

Verification
REQ-029 Single A word: WIDTH=4, valid_a=1, data_a=4'b1011 at cycle 0 -> ready_a=1 in cycle 0; ser_o=1,0,1,1 in cycles 1-4 with ser_en_o=1; done_o=1 in cycle 5; busy_o=0 in cycle 6.
REQ-030 Tie fairness: valid_a and valid_b held high continuously, data_a=4'hA, data_b=4'h5 -> grants alternate A,B,A,B; ser_o streams 1010, 0101, 1010, 0101; acceptances 6 cycles apart.
REQ-031 Busy backpressure: valid_b rises in cycle 2 of an A transfer -> ready_b=0 through cycle 5; B accepted in cycle 6; data_b changes during SHIFT do not alter ser_o.
REQ-032 Reset mid-SHIFT: reset_n=0 in cycle 3 -> ser_en_o, busy_o and done_o drop immediately; no done_o pulse; next tie grants A.
REQ-033 Parity build (SER_TX_PARITY_EN): data_a=4'b0111 -> ser_o=0,1,1,1,1 in cycles 1-5; done_o=1 in cycle 6; data 4'b0110 -> parity bit 0.
REQ-034 Idle hold: no valid for 20 cycles after reset -> all outputs stay at reset values; ready_a=ready_b=0.
